fir_coef_ctrl: RTL and testbench

//  Run-time coefficient controller for the 27-tap transposed FIR datapath.
//  - Accepts a serial coefficient stream into a shadow bank.
//  - Commits the shadow bank to the active bank atomically on a sample boundary.
//  - Clears the FIR delay line, then gates FIR output valid until the pipeline holds only new-coefficient products.

---
 rtl/fir_cfg_pkg.sv | 31 +++
 rtl/fir_coef_bank.sv | 52 +++++
 rtl/fir_coef_ctrl.sv | 141 ++++++++++++++
 tb/tb_fir_coef_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// Shared types and constants for the FIR coefficient controller.
// Build option: define FIR_COEF_SYMMETRIC_EN to load only half the taps and mirror them.
package fir_cfg_pkg;

    localparam int TAPS_DEFAULT          = 27;
    localparam int NUM_PRECISION_DEFAULT = 16;
    localparam int CNT_W_DEFAULT         = 5;

`ifdef FIR_COEF_SYMMETRIC_EN
    localparam bit SYMMETRIC_EN = 1'b1;
`else
    localparam bit SYMMETRIC_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Number of words a complete load takes for a filter of the given length.
    function automatic int nload(input int taps);
`ifdef FIR_COEF_SYMMETRIC_EN
        return (taps + 1) / 2;
`else
        return taps;
`endif
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register pair per tap; commit copies every shadow word at once.
// With MIRROR set, a write to tap k also lands on tap TAPS-1-k.
module fir_coef_bank
    import fir_cfg_pkg::*;
#(
    parameter int TAPS          = TAPS_DEFAULT,
    parameter int NUM_PRECISION = NUM_PRECISION_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT,
    parameter bit MIRROR        = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [CNT_W-1:0]              wr_idx,
    input  logic [NUM_PRECISION-1:0]      wr_data,
    input  logic                          commit,
    output logic [TAPS*NUM_PRECISION-1:0] coef_bus
);

    logic [CNT_W-1:0] mirror_idx;

    assign mirror_idx = CNT_W'(TAPS - 1) - wr_idx;

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            logic [NUM_PRECISION-1:0] shadow_reg;
            logic [NUM_PRECISION-1:0] active_reg;
            logic                     hit;

            // The centre tap matches both terms; it is still written exactly once.
            assign hit = wr_en && ((wr_idx == CNT_W'(gi)) ||
                                   (MIRROR && (mirror_idx == CNT_W'(gi))));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (hit) begin
                        shadow_reg <= wr_data;
                    end
                    if (commit) begin
                        active_reg <= shadow_reg;
                    end
                end
            end

            assign coef_bus[gi*NUM_PRECISION +: NUM_PRECISION] = active_reg;
        end
    endgenerate

endmodule

// File: rtl/fir_coef_ctrl.sv
// Run-time coefficient controller: serial load into a shadow bank, atomic commit on a
// sample boundary, delay-line clear and output gating until the pipeline is flushed.
// Build option FIR_COEF_SYMMETRIC_EN (see fir_cfg_pkg) halves the load length.
module fir_coef_ctrl
    import fir_cfg_pkg::*;
#(
    parameter int TAPS          = TAPS_DEFAULT,
    parameter int NUM_PRECISION = NUM_PRECISION_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [NUM_PRECISION-1:0]      cfg_data,
    input  logic                          sample_valid,
    output logic [TAPS*NUM_PRECISION-1:0] coef_bus,
    output logic                          fir_clear,
    output logic                          out_valid_gate,
    output logic                          busy,
    output logic                          load_err
);

    localparam int               NLOAD      = nload(TAPS);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NLOAD - 1);
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic             fir_clear_reg, fir_clear_next;
    logic             gate_reg, gate_next;
    logic             load_err_reg, load_err_next;
    logic             wr_en;
    logic             commit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            flush_cnt_reg <= '0;
            fir_clear_reg <= 1'b0;
            gate_reg      <= 1'b0;
            load_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            flush_cnt_reg <= flush_cnt_next;
            fir_clear_reg <= fir_clear_next;
            gate_reg      <= gate_next;
            load_err_reg  <= load_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        flush_cnt_next = flush_cnt_reg;
        fir_clear_next = 1'b0;
        gate_next      = gate_reg;
        load_err_next  = 1'b0;
        wr_en          = 1'b0;
        commit         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                end
            end

            ST_LOAD: begin
                // A restart beats a word offered in the same cycle; that word is dropped.
                if (cfg_start) begin
                    idx_next      = '0;
                    load_err_next = 1'b1;
                end else if (cfg_valid) begin
                    wr_en = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_ARMED;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + CNT_ONE;
                    end
                end
            end

            ST_ARMED: begin
                load_err_next = cfg_start;
                if (sample_valid) begin
                    commit         = 1'b1;
                    fir_clear_next = 1'b1;
                    gate_next      = 1'b0;
                    flush_cnt_next = FLUSH_INIT;
                    state_next     = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                load_err_next = cfg_start;
                // Gate opens once TAPS fresh samples have filled every product stage.
                if (sample_valid) begin
                    flush_cnt_next = flush_cnt_reg - CNT_ONE;
                    if (flush_cnt_reg == CNT_ONE) begin
                        gate_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cfg_ready      = (state_reg == ST_LOAD);
    assign busy           = (state_reg != ST_IDLE);
    assign fir_clear      = fir_clear_reg;
    assign out_valid_gate = gate_reg;
    assign load_err       = load_err_reg;

    fir_coef_bank #(
        .TAPS          (TAPS),
        .NUM_PRECISION (NUM_PRECISION),
        .CNT_W         (CNT_W),
        .MIRROR        (SYMMETRIC_EN)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_idx   (idx_reg),
        .wr_data  (cfg_data),
        .commit   (commit),
        .coef_bus (coef_bus)
    );

endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Scoreboard bench for fir_coef_ctrl: random loads/commits/flushes checked against a
// transaction-level model; a monitor pops expected commit, error and gate events.
module tb_fir_coef_ctrl;

    localparam int TAPS = 27;
    localparam int NP   = 16;
    localparam int BW   = TAPS * NP;
`ifdef FIR_COEF_SYMMETRIC_EN
    localparam int NLOAD = (TAPS + 1) / 2;
    localparam bit SYM   = 1'b1;
`else
    localparam int NLOAD = TAPS;
    localparam bit SYM   = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_ARMED = 2;
    localparam int M_FLUSH = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start, cfg_valid, sample_valid;
    logic [NP-1:0] cfg_data;
    logic          cfg_ready, fir_clear, out_valid_gate, busy, load_err;
    logic [BW-1:0] coef_bus;

    always #5 clk = ~clk;

    fir_coef_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_start      (cfg_start),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_data       (cfg_data),
        .sample_valid   (sample_valid),
        .coef_bus       (coef_bus),
        .fir_clear      (fir_clear),
        .out_valid_gate (out_valid_gate),
        .busy           (busy),
        .load_err       (load_err)
    );

    int checks = 0;
    int errors = 0;

    // Expected events: time of the posedge that should cause them (visible 5 later).
    time           commit_t_q[$];
    logic [BW-1:0] commit_bus_q[$];
    time           err_t_q[$];
    time           gate_t_q[$];

    // Reference model at transaction level.
    int            m_mode = M_IDLE;
    int            m_cnt  = 0;
    int            m_rem  = 0;
    logic          m_gate = 1'b0;
    logic [NP-1:0] m_shadow [TAPS];

    int tab_i [TAPS] = '{272, 449, -266, -1023, -312, 1184, 1024, -2048, -1600, 3000,
                         -5616, 2500, 7000, 9228, 7000, 2500, -5616, 3000, -1600, -2048,
                         1024, 1184, -312, -1023, -266, 449, 272};

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pack_shadow();
        logic [BW-1:0] b;
        for (int k = 0; k < TAPS; k++) b[k*NP +: NP] = m_shadow[k];
        return b;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cnt  = 0;
        m_rem  = 0;
        m_gate = 1'b0;
        for (int k = 0; k < TAPS; k++) m_shadow[k] = '0;
        commit_t_q.delete();
        commit_bus_q.delete();
        err_t_q.delete();
        gate_t_q.delete();
    endtask

    // One clock of stimulus; level outputs are checked before the edge, model advanced after.
    task automatic step(input logic st, input logic v, input logic [NP-1:0] d, input logic sv);
        @(negedge clk);
        cfg_start    = st;
        cfg_valid    = v;
        cfg_data     = d;
        sample_valid = sv;
        check("cfg_ready", BW'(cfg_ready), BW'(m_mode == M_LOAD));
        check("busy", BW'(busy), BW'(m_mode != M_IDLE));
        check("out_valid_gate", BW'(out_valid_gate), BW'(m_gate));
        @(posedge clk);
        case (m_mode)
            M_IDLE: if (st) begin m_mode = M_LOAD; m_cnt = 0; end
            M_LOAD: begin
                if (st) begin
                    m_cnt = 0;
                    err_t_q.push_back($time);
                end else if (v) begin
                    m_shadow[m_cnt] = d;
                    if (SYM) m_shadow[TAPS-1-m_cnt] = d;
                    m_cnt++;
                    if (m_cnt == NLOAD) m_mode = M_ARMED;
                end
            end
            M_ARMED: begin
                if (st) err_t_q.push_back($time);
                if (sv) begin
                    commit_t_q.push_back($time);
                    commit_bus_q.push_back(pack_shadow());
                    m_gate = 1'b0;
                    m_rem  = TAPS;
                    m_mode = M_FLUSH;
                end
            end
            default: begin
                if (st) err_t_q.push_back($time);
                if (sv) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_gate = 1'b1;
                        gate_t_q.push_back($time);
                        m_mode = M_IDLE;
                    end
                end
            end
        endcase
        #1;
        cfg_start    = 1'b0;
        cfg_valid    = 1'b0;
        sample_valid = 1'b0;
    endtask

    // Start a load and feed words until the model arms; optional restart at word abort_word.
    task automatic load(input bit use_tab, input int gap, input bit sv_rand, input int abort_word);
        int   guard;
        bit   aborted;
        logic v, st, sv;
        guard   = 0;
        aborted = 0;
        step(1'b1, 1'b0, '0, 1'b0);
        while (m_mode == M_LOAD && guard < 2000) begin
            v  = ($urandom_range(0, gap) == 0);
            sv = sv_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            st = 1'b0;
            if (abort_word >= 0 && !aborted && m_cnt == abort_word) begin
                st = 1'b1;
                v  = 1'b1;
                aborted = 1;
            end
            step(st, v, use_tab ? NP'(tab_i[m_cnt]) : NP'($urandom), sv);
            guard++;
        end
        check("load_armed", BW'(m_mode == M_ARMED), BW'(1));
    endtask

    // Drive random samples until commit and flush complete; optional cfg_start at flush_cnt.
    task automatic flush(input int abort_at);
        int   guard;
        bit   done_abort;
        logic st;
        guard      = 0;
        done_abort = 0;
        while (m_mode != M_IDLE && guard < 2000) begin
            st = 1'b0;
            if (abort_at >= 0 && !done_abort && m_mode == M_FLUSH && m_rem == abort_at) begin
                st = 1'b1;
                done_abort = 1;
            end
            step(st, 1'b0, '0, 1'($urandom_range(0, 1)));
            guard++;
        end
        check("flush_done", BW'(m_mode == M_IDLE), BW'(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst coef_bus", coef_bus, '0);
        check("rst cfg_ready", BW'(cfg_ready), '0);
        check("rst fir_clear", BW'(fir_clear), '0);
        check("rst gate", BW'(out_valid_gate), '0);
        check("rst busy", BW'(busy), '0);
        check("rst load_err", BW'(load_err), '0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every DUT event must match the oldest expected one, one half-cycle after its edge.
    logic [BW-1:0] prev_bus;
    always @(negedge clk) begin
        if (!reset) begin
            prev_bus = coef_bus;
        end else begin
            if (fir_clear) begin
                if (commit_t_q.size() == 0) begin
                    check("unexpected fir_clear", BW'(fir_clear), '0);
                end else begin
                    check("commit time", BW'($time - commit_t_q.pop_front()), BW'(5));
                    check("commit coef_bus", coef_bus, commit_bus_q.pop_front());
                    $display("commit at %0t tap0=%0d", $time, $signed(coef_bus[NP-1:0]));
                end
            end else begin
                check("coef_bus stable", coef_bus, prev_bus);
            end
            prev_bus = coef_bus;
            if (load_err) begin
                if (err_t_q.size() == 0) check("unexpected load_err", BW'(load_err), '0);
                else begin
                    check("load_err time", BW'($time - err_t_q.pop_front()), BW'(5));
                    $display("load_err at %0t", $time);
                end
            end
            if (out_valid_gate && gate_t_q.size() != 0) begin
                check("gate time", BW'($time - gate_t_q[0]), BW'(5));
                void'(gate_t_q.pop_front());
                $display("gate open at %0t", $time);
            end
        end
    end

    initial begin
        reset        = 1'b0;
        cfg_start    = 1'b0;
        cfg_valid    = 1'b0;
        cfg_data     = '0;
        sample_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("init coef_bus", coef_bus, '0);
        check("init busy", BW'(busy), '0);
        check("init gate", BW'(out_valid_gate), '0);
        check("init cfg_ready", BW'(cfg_ready), '0);
        reset = 1'b1;

        // Reset in the middle of a load after 10 words.
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, NP'($urandom), 1'b0);
        do_reset();
        step(1'b0, 1'b0, '0, 1'b1);

        // Table load, commit, sign-intact taps visible the following cycle.
        load(1'b1, 0, 1'b0, -1);
        step(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("fir_clear after commit", BW'(fir_clear), BW'(1));
        check("tap13", BW'(coef_bus[13*NP +: NP]), BW'(16'd9228));
        check("tap10", BW'(coef_bus[10*NP +: NP]), BW'(16'hEA10));
        check("tap0", BW'(coef_bus[0 +: NP]), BW'(16'd272));
        check("tap26", BW'(coef_bus[26*NP +: NP]), BW'(16'd272));
        flush(-1);

        // Restart at word 5 with cfg_valid held high.
        load(1'b0, 0, 1'b0, 5);
        flush(-1);

        // cfg_start during flush with 12 samples still to go.
        load(1'b0, 1, 1'b0, -1);
        flush(12);

        // Gapped words (1 in 3) with samples arriving during the load.
        load(1'b0, 2, 1'b1, -1);
        flush(-1);

        // Random rounds.
        for (int r = 0; r < 6; r++) begin
            load(1'b0, int'($urandom_range(0, 3)), 1'b1,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NLOAD - 1)) : -1);
            flush(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, TAPS)) : -1);
        end

        repeat (3) @(negedge clk);
        check("pending commits", BW'(commit_t_q.size()), '0);
        check("pending load_err", BW'(err_t_q.size()), '0);
        check("pending gate", BW'(gate_t_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
